// File: rtl/round_ctrl.sv
// round_ctrl: quiz-round sequencer. Arms a countdown timer, waits for an
// answer or a timer expiry, flags the outcome for one cycle, accumulates a
// time-bonus score and stops after MAX_ROUNDS rounds until reset.
module round_ctrl #(
  parameter int MAX_ROUNDS = 10,
  parameter int TIMER_MAX  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_round,
  input  logic       answer_valid,
  input  logic       answer_correct,
  input  logic [2:0] timer_out,
  output logic       timer_start,
  output logic       round_active,
  output logic       correct_pulse,
  output logic       wrong_pulse,
  output logic       timeout_pulse,
  output logic [7:0] score,
  output logic [3:0] rounds_played,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_RUN    = 3'd2,
    S_RESULT = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam logic [2:0] TMAX_3     = 3'(TIMER_MAX);
  localparam logic [3:0] MAX_ROUNDS_4 = 4'(MAX_ROUNDS);

  state_t     state_q, state_d;
  logic       timer_start_q, timer_start_d;
  logic       round_active_q, round_active_d;
  logic       correct_pulse_q, correct_pulse_d;
  logic       wrong_pulse_q, wrong_pulse_d;
  logic       timeout_pulse_q, timeout_pulse_d;
  logic [7:0] score_q, score_d;
  logic [3:0] rounds_played_q, rounds_played_d;
  logic       game_over_q, game_over_d;
  logic       decide;

  // Bonus for a correct answer: one point plus the remaining time, clamped.
  function automatic logic [3:0] round_bonus(input logic [2:0] t);
    logic [2:0] c;
    c = (t > TMAX_3) ? TMAX_3 : t;
    return 4'd1 + {1'b0, c};
  endfunction

  // 9-bit add that pins the score at 255 instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] s, input logic [3:0] b);
    logic [8:0] sum;
    sum = {1'b0, s} + {5'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      timer_start_q   <= 1'b0;
      round_active_q  <= 1'b0;
      correct_pulse_q <= 1'b0;
      wrong_pulse_q   <= 1'b0;
      timeout_pulse_q <= 1'b0;
      score_q         <= 8'd0;
      rounds_played_q <= 4'd0;
      game_over_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_start_q   <= timer_start_d;
      round_active_q  <= round_active_d;
      correct_pulse_q <= correct_pulse_d;
      wrong_pulse_q   <= wrong_pulse_d;
      timeout_pulse_q <= timeout_pulse_d;
      score_q         <= score_d;
      rounds_played_q <= rounds_played_d;
      game_over_q     <= game_over_d;
    end
  end

  // Next-state logic; an answer in RUN takes precedence over timer expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_round) state_d = S_ARM;
      S_ARM:    state_d = S_RUN;
      S_RUN:    if (answer_valid || (timer_out == 3'd0)) state_d = S_RESULT;
      // rounds_played_q already holds the count including this round
      S_RESULT: state_d = (rounds_played_q == MAX_ROUNDS_4) ? S_OVER : S_IDLE;
      S_OVER:   state_d = S_OVER;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output next values, computed from the state being entered so the
  // registered outputs line up with that state's cycle.
  always_comb begin
    decide          = (state_q == S_RUN) && (answer_valid || (timer_out == 3'd0));
    timer_start_d   = (state_d == S_ARM) || (state_d == S_RUN);
    round_active_d  = (state_d == S_ARM) || (state_d == S_RUN);
    correct_pulse_d = (state_q == S_RUN) && answer_valid && answer_correct;
    wrong_pulse_d   = (state_q == S_RUN) && answer_valid && !answer_correct;
    timeout_pulse_d = (state_q == S_RUN) && !answer_valid && (timer_out == 3'd0);
    score_d         = correct_pulse_d ? sat_add(score_q, round_bonus(timer_out)) : score_q;
    rounds_played_d = decide ? rounds_played_q + 4'd1 : rounds_played_q;
    game_over_d     = (state_d == S_OVER);
  end

  assign timer_start   = timer_start_q;
  assign round_active  = round_active_q;
  assign correct_pulse = correct_pulse_q;
  assign wrong_pulse   = wrong_pulse_q;
  assign timeout_pulse = timeout_pulse_q;
  assign score         = score_q;
  assign rounds_played = rounds_played_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_round_ctrl.sv
// tb_round_ctrl: randomized rounds against a round-level reference model of
// the quiz sequencer (score, round count, per-phase output expectations).
module tb_round_ctrl;
  localparam int MAXR = 3;
  localparam int TMAX = 5;

  logic       clk = 1'b0;
  logic       reset, start_round, answer_valid, answer_correct;
  logic [2:0] timer_out;
  logic       timer_start, round_active, correct_pulse, wrong_pulse, timeout_pulse;
  logic [7:0] score;
  logic [3:0] rounds_played;
  logic       game_over;

  int total = 0;
  int bad   = 0;
  int exp_score, exp_rounds;

  round_ctrl #(.MAX_ROUNDS(MAXR), .TIMER_MAX(TMAX)) dut (
    .clk(clk), .reset(reset), .start_round(start_round),
    .answer_valid(answer_valid), .answer_correct(answer_correct),
    .timer_out(timer_out), .timer_start(timer_start), .round_active(round_active),
    .correct_pulse(correct_pulse), .wrong_pulse(wrong_pulse),
    .timeout_pulse(timeout_pulse), .score(score), .rounds_played(rounds_played),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Outputs expected outside ARM/RUN/RESULT, plus the model's totals.
  task automatic check_quiet(input string tag, input bit over);
    check_eq({tag, ".ts"}, timer_start, 0);
    check_eq({tag, ".ra"}, round_active, 0);
    check_eq({tag, ".pulses"}, {correct_pulse, wrong_pulse, timeout_pulse}, 0);
    check_eq({tag, ".score"}, score, exp_score);
    check_eq({tag, ".rounds"}, rounds_played, exp_rounds);
    check_eq({tag, ".go"}, game_over, over);
  endtask

  task automatic do_reset();
    reset = 1'b1; start_round = 1'b1; answer_valid = 1'b1; answer_correct = 1'b1;
    timer_out = 3'd0;
    tick();
    exp_score = 0; exp_rounds = 0;
    sample();
    check_quiet("reset", 0);
    reset = 1'b0; start_round = 1'b0; answer_valid = 1'b0; answer_correct = 1'b0;
    timer_out = 3'(TMAX);
    tick();
    sample();
    check_quiet("post_reset", 0);
    tick();
  endtask

  // One round: waits RUN cycles without a decision, then either an answer
  // (with timer value tv) or a timer expiry.
  task automatic play_round(input int waits, input bit ans, input bit corr, input logic [2:0] tv);
    int bonus;
    start_round = 1'b1;
    tick();
    start_round = 1'b0;
    answer_valid = 1'($urandom % 2); answer_correct = 1'($urandom % 2); timer_out = 3'd0;
    sample();
    check_eq("arm.ts", timer_start, 1);
    check_eq("arm.ra", round_active, 1);
    check_eq("arm.pulses", {correct_pulse, wrong_pulse, timeout_pulse}, 0);
    tick();
    for (int i = 0; i < waits; i++) begin
      answer_valid = 1'b0; timer_out = 3'($urandom_range(7, 1));
      start_round = 1'($urandom % 2);
      sample();
      check_eq("run.ts", timer_start, 1);
      check_eq("run.ra", round_active, 1);
      check_eq("run.pulses", {correct_pulse, wrong_pulse, timeout_pulse}, 0);
      tick();
    end
    answer_valid = ans; answer_correct = corr; timer_out = ans ? tv : 3'd0;
    start_round = 1'($urandom % 2);
    sample();
    check_eq("decide.ts", timer_start, 1);
    tick();
    answer_valid = 1'b0; answer_correct = 1'b0; start_round = 1'b0; timer_out = 3'(TMAX);
    exp_rounds++;
    if (ans && corr) begin
      bonus = 1 + ((int'(tv) > TMAX) ? TMAX : int'(tv));
      exp_score = (exp_score + bonus > 255) ? 255 : exp_score + bonus;
    end
    sample();
    check_eq("result.correct", correct_pulse, ans && corr);
    check_eq("result.wrong", wrong_pulse, ans && !corr);
    check_eq("result.timeout", timeout_pulse, !ans);
    check_eq("result.ts", timer_start, 0);
    check_eq("result.ra", round_active, 0);
    check_eq("result.score", score, exp_score);
    check_eq("result.rounds", rounds_played, exp_rounds);
    check_eq("result.go", game_over, 0);
    tick();
    sample();
    check_quiet("after_result", exp_rounds == MAXR);
    tick();
  endtask

  initial begin
    reset = 1'b1; start_round = 1'b0; answer_valid = 1'b0; answer_correct = 1'b0;
    timer_out = 3'(TMAX);
    do_reset();

    // correct answer at timer 3 -> score 4
    play_round(0, 1, 1, 3'd3);
    // timeout after counting down
    play_round(3, 0, 0, 3'd0);
    // answer and expiry together: answer wins, wrong
    play_round(1, 1, 0, 3'd0);

    // game over: further starts and answers produce nothing
    for (int i = 0; i < 4; i++) begin
      start_round = 1'b1; answer_valid = 1'b1; answer_correct = 1'b1; timer_out = 3'd0;
      sample();
      check_quiet("over_hold", 1);
      tick();
    end

    // saturation: preload score to 252
    do_reset();
    force dut.score_q = 8'd252;
    tick();
    release dut.score_q;
    exp_score = 252;
    play_round(0, 1, 1, 3'd5);
    play_round(2, 1, 1, 3'd7);

    // reset in the middle of RUN with an answer present
    do_reset();
    start_round = 1'b1;
    tick();
    start_round = 1'b0;
    tick();
    reset = 1'b1; answer_valid = 1'b1; answer_correct = 1'b1; timer_out = 3'd4;
    tick();
    exp_score = 0; exp_rounds = 0;
    sample();
    check_quiet("mid_reset", 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      sample();
      check_quiet("idle_answers", 0);
    end
    answer_valid = 1'b0; answer_correct = 1'b0;
    tick();

    // randomized games
    for (int g = 0; g < 6; g++) begin
      do_reset();
      for (int r = 0; r < MAXR; r++) begin
        play_round(int'($urandom_range(4, 0)), 1'($urandom % 4 != 0),
                   1'($urandom % 2), 3'($urandom_range(7, 0)));
        if (exp_rounds < MAXR) begin
          for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
            sample();
            check_quiet("idle_gap", 0);
            tick();
          end
        end
      end
      sample();
      check_quiet("game_end", 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 The block SHALL have the parameter MAX_ROUNDS, default 10, meaning the number of rounds per game (range 1..15).
REQ-002 The block SHALL have the parameter TIMER_MAX, default 5, meaning the full countdown value expected from the timer.
REQ-003 The block SHALL have the port clk  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port reset  input  1  meaning the reset, which is synchronous and active-high.
REQ-005 The block SHALL have the port start_round  input  1  meaning a request to begin a round, sampled only in IDLE.
REQ-006 The block SHALL have the port answer_valid  input  1  meaning the player has submitted an answer this cycle.
REQ-007 The block SHALL have the port answer_correct  input  1  meaning the submitted answer is correct, qualified by answer_valid.
REQ-008 The block SHALL have the port timer_out  input  3  meaning the remaining count from the countdown timer.
REQ-009 The block SHALL have the port timer_start  output  1  meaning the run-enable to the countdown timer; while low, the timer holds TIMER_MAX.
REQ-010 The block SHALL have the port round_active  output  1  meaning the block is in ARM or RUN.
REQ-011 The block SHALL have the port correct_pulse  output  1  meaning a one-cycle flag for a correct answer.
REQ-012 The block SHALL have the port wrong_pulse  output  1  meaning a one-cycle flag for a wrong answer.
REQ-013 The block SHALL have the port timeout_pulse  output  1  meaning a one-cycle flag for timer expiry.
REQ-014 The block SHALL have the port score  output  8  meaning the accumulated score.
REQ-015 The block SHALL have the port rounds_played  output  4  meaning the number of completed rounds.
REQ-016 The block SHALL have the port game_over  output  1  meaning the game is over after MAX_ROUNDS rounds.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 The FSM SHALL have exactly five states: IDLE, ARM, RUN, RESULT and OVER.
REQ-019 In IDLE, start_round=1 SHALL move the FSM to ARM on the next edge; start_round in any other state SHALL be ignored.
REQ-020 ARM SHALL last exactly 1 cycle, with timer_start=1, and SHALL then move to RUN; answer_valid and timer_out SHALL be ignored in ARM.
REQ-021 In RUN, timer_start SHALL stay 1.
REQ-022 In RUN, answer_valid=1 SHALL move the FSM to RESULT; correct_pulse or wrong_pulse (per answer_correct) SHALL be 1 in the RESULT cycle.
REQ-023 In RUN, timer_out==0 with answer_valid=0 SHALL move the FSM to RESULT with timeout_pulse=1 in the RESULT cycle.
REQ-024 In RUN, if answer_valid=1 and timer_out==0 in the same cycle, the answer SHALL win, and timeout_pulse SHALL stay 0.
REQ-025 On a correct answer, score SHALL add 1 + min(timer_out, TIMER_MAX) sampled in the accepting RUN cycle.
REQ-026 The score addition SHALL be computed 9 bits wide and saturate at 255.
REQ-027 Wrong answers and timeouts SHALL leave score unchanged.
REQ-028 RESULT SHALL last 1 cycle, with timer_start=0 so the timer reloads.
REQ-029 rounds_played SHALL increment by 1 in the RESULT cycle.
REQ-030 From RESULT, the FSM SHALL go to OVER if the incremented rounds_played == MAX_ROUNDS, otherwise to IDLE.
REQ-031 In OVER, game_over SHALL be 1 and timer_start 0; all inputs SHALL be ignored, and OVER SHALL be left only by reset.
REQ-032 round_active SHALL be 1 exactly in ARM and RUN.
REQ-033 At most one of the three pulses SHALL be high in any cycle, and the pulses SHALL be high only in RESULT.
REQ-034 Latency SHALL be 2 cycles from start_round to the first RUN cycle, and 1 cycle from the deciding RUN cycle to the pulse.

Reset
REQ-035 reset=1 at an edge SHALL force IDLE, timer_start=0, round_active=0, all pulses=0, score=0, rounds_played=0 and game_over=0.
REQ-036 reset SHALL take priority over every other input in every state, including mid-RUN and OVER.
REQ-037 After reset deasserts, no pulse SHALL occur until a new round completes.

Verification
REQ-038 Correct-with-bonus scenario: reset, then start_round 1 cycle, then answer_valid=1 and answer_correct=1 when timer_out=3 -> correct_pulse 1 cycle, score=4, rounds_played=1, FSM back in IDLE.
REQ-039 Timeout scenario: start round, no answer, timer counts to 0 -> timeout_pulse 1 cycle, score unchanged, timer_start=0 in the RESULT cycle.
REQ-040 Simultaneous-event scenario: answer_valid=1 and answer_correct=0 in the same cycle that timer_out==0 -> wrong_pulse=1, timeout_pulse=0.
REQ-041 Saturation scenario: preload to score 252, then a correct answer with timer_out=5 -> score=255, not 2.
REQ-042 Game-over scenario: with MAX_ROUNDS=3, play 3 rounds -> game_over=1 after the 3rd RESULT; a further start_round produces no ARM.
REQ-043 Reset-mid-round scenario: assert reset in a RUN cycle -> next cycle IDLE, timer_start=0, score=0 and no pulse; answers in IDLE and ARM are ignored.
